// File: rtl/cpu_boot_seq_pkg.sv
// Shared state encoding and default sizes for the cpu_boot_seq boot sequencer.
package cpu_boot_seq_pkg;

  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefRegN       = 32;
  localparam int unsigned DefImemDepth  = 256;
  localparam int unsigned DefHoldCycles = 4;

  typedef enum logic [2:0] {
    StRegInit = 3'd0,
    StImgLoad = 3'd1,
    StFill    = 3'd2,
    StHold    = 3'd3,
    StRun     = 3'd4,
    StFault   = 3'd5
  } boot_state_e;

  function automatic int unsigned max_w(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boot_hold_cnt.sv
// Loadable down-counter with a terminal-count flag; used to time the core reset hold.
module boot_hold_cnt #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_boot_seq.sv
// Boot sequencer: register-file init, instruction image load, timed core reset release.
// Optional zero fill of unused instruction memory is enabled by CPU_BOOT_ZERO_FILL_EN.
module cpu_boot_seq
  import cpu_boot_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned REG_N       = DefRegN,
  parameter int unsigned REG_AW      = $clog2(REG_N),
  parameter int unsigned IMEM_DEPTH  = DefImemDepth,
  parameter int unsigned IMEM_AW     = $clog2(IMEM_DEPTH),
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               img_valid_i,
  output logic               img_ready_o,
  input  logic [DATA_W-1:0]  img_data_i,
  input  logic               img_last_i,
  output logic               rf_we_o,
  output logic [REG_AW-1:0]  rf_waddr_o,
  output logic [DATA_W-1:0]  rf_wdata_o,
  output logic               im_we_o,
  output logic [IMEM_AW-1:0] im_addr_o,
  output logic [DATA_W-1:0]  im_wdata_o,
  output logic               cpu_reset_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned CntW  = max_w(REG_AW, IMEM_AW);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CntW-1:0]  RegLast  = CntW'(REG_N - 1);
  localparam logic [CntW-1:0]  ImemLast = CntW'(IMEM_DEPTH - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  boot_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q, err_q, cpu_reset_q;
  logic            xfer, enter_hold, hold_tc;

  // Handshake is masked while reset is asserted so nothing is accepted during abort.
  assign img_ready_o = (state_q == StImgLoad) && !reset_i;
  assign xfer        = img_valid_i && img_ready_o;

  always_comb begin
    enter_hold = 1'b0;
    unique case (state_q)
      StImgLoad: begin
`ifdef CPU_BOOT_ZERO_FILL_EN
        enter_hold = xfer && img_last_i && (cnt_q == ImemLast);
`else
        enter_hold = xfer && img_last_i;
`endif
      end
`ifdef CPU_BOOT_ZERO_FILL_EN
      StFill:  enter_hold = (cnt_q == ImemLast);
`endif
      default: enter_hold = 1'b0;
    endcase
  end

  boot_hold_cnt #(
    .Width (HoldW)
  ) u_hold_cnt (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (enter_hold),
    .load_val_i (HoldLoad),
    .en_i       (state_q == StHold),
    .tc_o       (hold_tc)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StRegInit;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRegInit: begin
          if (cnt_q == RegLast) begin
            cnt_q   <= '0;
            state_q <= StImgLoad;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StImgLoad: begin
          if (xfer) begin
            if (!img_last_i && (cnt_q == ImemLast)) begin
              err_q   <= 1'b1;
              state_q <= StFault;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (img_last_i) begin
                state_q <= enter_hold ? StHold : StFill;
              end
            end
          end
        end
`ifdef CPU_BOOT_ZERO_FILL_EN
        StFill: begin
          if (enter_hold) begin
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StHold: begin
          if (hold_tc) begin
            state_q     <= StRun;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
          end
        end
        StRun, StFault: begin
          state_q <= state_q;
        end
        default: state_q <= StFault;
      endcase
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    im_we_o    = 1'b0;
    im_addr_o  = '0;
    im_wdata_o = '0;
    if (!reset_i) begin
      unique case (state_q)
        StRegInit: begin
          rf_we_o    = 1'b1;
          rf_waddr_o = cnt_q[REG_AW-1:0];
          rf_wdata_o = DATA_W'(cnt_q[REG_AW-1:0]);
        end
        StImgLoad: begin
          im_we_o    = xfer;
          im_addr_o  = cnt_q[IMEM_AW-1:0];
          im_wdata_o = xfer ? img_data_i : '0;
        end
`ifdef CPU_BOOT_ZERO_FILL_EN
        StFill: begin
          im_we_o   = 1'b1;
          im_addr_o = cnt_q[IMEM_AW-1:0];
        end
`endif
        default: begin
          im_we_o = 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset_o = cpu_reset_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cpu_boot_seq.sv
// Randomised self-checking bench for cpu_boot_seq against a transaction-level boot model.
module tb_cpu_boot_seq;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned REG_N       = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned IMEM_DEPTH  = 4;
  localparam int unsigned IMEM_AW     = 2;
  localparam int unsigned HOLD_CYCLES = 4;
  localparam int          RunCycles   = 70;
`ifdef CPU_BOOT_ZERO_FILL_EN
  localparam bit ZeroFill = 1'b1;
`else
  localparam bit ZeroFill = 1'b0;
`endif

  logic               clock     = 1'b0;
  logic               reset     = 1'b1;
  logic               img_valid = 1'b0;
  logic               img_last  = 1'b0;
  logic [DATA_W-1:0]  img_data  = '0;
  logic               img_ready, rf_we, im_we, cpu_reset, done, err;
  logic [REG_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0]  rf_wdata, im_wdata;
  logic [IMEM_AW-1:0] im_addr;

  always #5 clock = ~clock;

  cpu_boot_seq #(
    .DATA_W      (DATA_W),
    .REG_N       (REG_N),
    .REG_AW      (REG_AW),
    .IMEM_DEPTH  (IMEM_DEPTH),
    .IMEM_AW     (IMEM_AW),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .img_valid_i (img_valid),
    .img_ready_o (img_ready),
    .img_data_i  (img_data),
    .img_last_i  (img_last),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .im_we_o     (im_we),
    .im_addr_o   (im_addr),
    .im_wdata_o  (im_wdata),
    .cpu_reset_o (cpu_reset),
    .done_o      (done),
    .err_o       (err)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] img_words [8];
  bit                pat [16];
  int                patlen;

  // Observed writes, tagged with the clock edge (1 = first edge after reset release).
  int                rf_addr_q[$], rf_edge_q[$], im_addr_q[$], im_edge_q[$];
  logic [DATA_W-1:0] rf_data_q[$], im_data_q[$];
  int                done_edge, cpurst_edge, err_edge, early_ready, overlap;

  int                exp_addr_q[$], exp_edge_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  int                exp_done, exp_err;

  function automatic bit valid_at(int j);
    return (j < 0 || j >= patlen) ? 1'b1 : pat[j];
  endfunction

  // Model: beats land in order on offered cycles of the load window; a missing last beat
  // at full depth is a fault; the core is released HOLD_CYCLES after the image (and fill).
  task automatic build_model(input int nbeats, input bit has_last);
    int taken = 0;
    int j = 0;
    int edge_n;
    exp_addr_q.delete(); exp_data_q.delete(); exp_edge_q.delete();
    exp_done = -1;
    exp_err  = -1;
    while (taken < nbeats && exp_err < 0) begin
      if (valid_at(j)) begin
        edge_n = REG_N + 1 + j;
        exp_addr_q.push_back(taken);
        exp_data_q.push_back(img_words[taken]);
        exp_edge_q.push_back(edge_n);
        taken++;
        if (has_last && taken == nbeats) begin
          int fill = ZeroFill ? int'(IMEM_DEPTH) - taken : 0;
          for (int k = 0; k < fill; k++) begin
            exp_addr_q.push_back(taken + k);
            exp_data_q.push_back('0);
            exp_edge_q.push_back(edge_n + 1 + k);
          end
          exp_done = edge_n + fill + int'(HOLD_CYCLES);
        end else if (taken == int'(IMEM_DEPTH)) begin
          exp_err = edge_n;
        end
      end
      j++;
    end
  endtask

  task automatic run_boot(input int nbeats, input bit has_last, input int ncycles);
    int b = 0;
    rf_addr_q.delete(); rf_data_q.delete(); rf_edge_q.delete();
    im_addr_q.delete(); im_data_q.delete(); im_edge_q.delete();
    done_edge = -1; cpurst_edge = -1; err_edge = -1; early_ready = 0; overlap = 0;
    reset = 1'b1;
    img_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 1; c <= ncycles; c++) begin
      img_valid = (b < nbeats) && valid_at(c - int'(REG_N) - 1);
      img_data  = img_words[(b < 8) ? b : 7];
      img_last  = has_last && (b == nbeats - 1);
      @(negedge clock);
      if (rf_we) begin
        rf_addr_q.push_back(int'(rf_waddr)); rf_data_q.push_back(rf_wdata); rf_edge_q.push_back(c);
      end
      if (im_we) begin
        im_addr_q.push_back(int'(im_addr)); im_data_q.push_back(im_wdata); im_edge_q.push_back(c);
      end
      if (rf_we && im_we) overlap++;
      if (img_ready && c <= int'(REG_N)) early_ready++;
      if (done && done_edge < 0) done_edge = c - 1;
      if (cpu_reset && cpurst_edge < 0) cpurst_edge = c - 1;
      if (err && err_edge < 0) err_edge = c - 1;
      if (img_valid && img_ready) b++;
      @(posedge clock);
      #1;
    end
    img_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    img_valid = 1'b1;
    img_last = 1'b1;
    img_data = $urandom;
    repeat (3) @(negedge clock);
    checks++;
    if ({rf_we, im_we, img_ready, done, err, cpu_reset} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {rf_we, im_we, img_ready, done, err, cpu_reset});
    end
    checks++;
    if (rf_waddr !== '0 || rf_wdata !== '0 || im_addr !== '0 || im_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want all zero", rf_waddr, rf_wdata, im_addr, im_wdata);
    end
    img_valid = 1'b0;
    img_last = 1'b0;
  endtask

  task automatic test_boot();
    int bad = 0;
    img_words[0] = 32'h2010_0009; img_words[1] = 32'h0000_0000; img_words[2] = 32'h8C08_0004;
    patlen = 0;
    build_model(3, 1'b1);
    run_boot(3, 1'b1, RunCycles);
    checks++;
    if (rf_addr_q.size() != int'(REG_N)) begin
      errors++; $display("FAIL boot_rf_count: got %0d want %0d", rf_addr_q.size(), REG_N);
    end else begin
      for (int i = 0; i < int'(REG_N); i++) begin
        checks++;
        if (rf_addr_q[i] != i || rf_data_q[i] !== DATA_W'(i) || rf_edge_q[i] != i + 1) begin
          errors++;
          $display("FAIL boot_rf[%0d]: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                   i, rf_addr_q[i], rf_data_q[i], rf_edge_q[i], i, i, i + 1);
        end
      end
    end
    checks++;
    if (im_addr_q.size() != exp_addr_q.size()) begin
      errors++; $display("FAIL boot_im_count: got %0d want %0d", im_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (im_addr_q[i] != exp_addr_q[i] || im_data_q[i] !== exp_data_q[i]
            || im_edge_q[i] != exp_edge_q[i]) begin
          errors++;
          $display("FAIL boot_im[%0d]: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                   i, im_addr_q[i], im_data_q[i], im_edge_q[i], exp_addr_q[i], exp_data_q[i],
                   exp_edge_q[i]);
        end
      end
    end
    checks++;
    if (done_edge != exp_done) begin
      errors++; $display("FAIL boot_done_edge: got %0d want %0d", done_edge, exp_done);
    end
    checks++;
    if (cpurst_edge != exp_done) begin
      errors++; $display("FAIL boot_cpu_reset_edge: got %0d want %0d", cpurst_edge, exp_done);
    end
    checks++;
    if (err_edge != -1 || overlap != 0 || early_ready != 0) begin
      errors++;
      $display("FAIL boot_side: got err_edge %0d overlap %0d early_ready %0d want -1 0 0",
               err_edge, overlap, early_ready);
    end
    // Beats offered once running must be ignored.
    for (int i = 0; i < 4; i++) begin
      img_valid = 1'b1;
      img_data = $urandom;
      @(negedge clock);
      if (im_we || img_ready || rf_we || !done) bad++;
      @(posedge clock);
      #1;
    end
    img_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL run_ignores_beats: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) img_words[i] = $urandom;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
    patlen = 5;
    build_model(3, 1'b1);
    run_boot(3, 1'b1, RunCycles);
    checks++;
    if (im_addr_q.size() != exp_addr_q.size()) begin
      errors++; $display("FAIL bp_im_count: got %0d want %0d", im_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (im_addr_q[i] != exp_addr_q[i] || im_data_q[i] !== exp_data_q[i]
            || im_edge_q[i] != exp_edge_q[i]) begin
          errors++;
          $display("FAIL bp_im[%0d]: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                   i, im_addr_q[i], im_data_q[i], im_edge_q[i], exp_addr_q[i], exp_data_q[i],
                   exp_edge_q[i]);
        end
      end
    end
    checks++;
    if (done_edge != exp_done) begin
      errors++; $display("FAIL bp_done_edge: got %0d want %0d", done_edge, exp_done);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) img_words[i] = $urandom;
    patlen = 0;
    build_model(5, 1'b0);
    run_boot(5, 1'b0, RunCycles);
    checks++;
    if (im_addr_q.size() != exp_addr_q.size()) begin
      errors++; $display("FAIL ovf_im_count: got %0d want %0d", im_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (im_addr_q[i] != exp_addr_q[i] || im_data_q[i] !== exp_data_q[i]) begin
          errors++;
          $display("FAIL ovf_im[%0d]: got addr %0d data %h want addr %0d data %h",
                   i, im_addr_q[i], im_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
    end
    checks++;
    if (err_edge != exp_err) begin
      errors++; $display("FAIL ovf_err_edge: got %0d want %0d", err_edge, exp_err);
    end
    checks++;
    if (done_edge != -1 || cpurst_edge != -1 || err !== 1'b1 || img_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_terminal: got done_edge %0d cpurst_edge %0d err %b ready %b want -1 -1 1 0",
               done_edge, cpurst_edge, err, img_ready);
    end
  endtask

  task automatic test_exact_fit();
    for (int i = 0; i < 4; i++) img_words[i] = $urandom;
    patlen = 0;
    build_model(4, 1'b1);
    run_boot(4, 1'b1, RunCycles);
    checks++;
    if (err_edge != -1 || done_edge != exp_done || im_addr_q.size() != exp_addr_q.size()) begin
      errors++;
      $display("FAIL fit: got err_edge %0d done_edge %0d writes %0d want -1 %0d %0d",
               err_edge, done_edge, im_addr_q.size(), exp_done, exp_addr_q.size());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 2; i++) img_words[i] = $urandom;
    patlen = 0;
    build_model(2, 1'b1);
    run_boot(2, 1'b1, RunCycles);
    checks++;
    if (im_addr_q.size() != exp_addr_q.size()) begin
      errors++; $display("FAIL fill_count: got %0d want %0d", im_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (im_addr_q[i] != exp_addr_q[i] || im_data_q[i] !== exp_data_q[i]
            || im_edge_q[i] != exp_edge_q[i]) begin
          errors++;
          $display("FAIL fill_im[%0d]: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                   i, im_addr_q[i], im_data_q[i], im_edge_q[i], exp_addr_q[i], exp_data_q[i],
                   exp_edge_q[i]);
        end
      end
    end
    checks++;
    if (done_edge != exp_done) begin
      errors++; $display("FAIL fill_done_edge: got %0d want %0d", done_edge, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) img_words[i] = $urandom;
    patlen = 0;
    run_boot(3, 1'b1, REG_N + 1);
    img_valid = 1'b1;
    img_data = img_words[1];
    #2;
    checks++;
    if (img_ready !== 1'b1 || im_we !== 1'b1 || im_addr !== 2'd1) begin
      errors++;
      $display("FAIL mid_loading: got ready %b we %b addr %0d want 1 1 1", img_ready, im_we, im_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rf_we, im_we, img_ready, done, err, cpu_reset} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got %b want 000000",
               {rf_we, im_we, img_ready, done, err, cpu_reset});
    end
    build_model(3, 1'b1);
    run_boot(3, 1'b1, RunCycles);
    checks++;
    if (rf_addr_q.size() == 0 || rf_addr_q[0] != 0 || rf_edge_q[0] != 1) begin
      errors++;
      $display("FAIL mid_restart_rf: got count %0d first addr %0d want first addr 0 at edge 1",
               rf_addr_q.size(), (rf_addr_q.size() != 0) ? rf_addr_q[0] : -1);
    end
    checks++;
    if (done_edge != exp_done || im_addr_q.size() != exp_addr_q.size()) begin
      errors++;
      $display("FAIL mid_restart_boot: got done_edge %0d writes %0d want %0d %0d",
               done_edge, im_addr_q.size(), exp_done, exp_addr_q.size());
    end
  endtask

  task automatic test_random();
    int  nbeats;
    bit  has_last;
    for (int it = 0; it < 8; it++) begin
      has_last = ($urandom_range(0, 4) != 0);
      nbeats = has_last ? int'($urandom_range(1, IMEM_DEPTH)) : int'(IMEM_DEPTH) + 1;
      for (int i = 0; i < nbeats; i++) img_words[i] = $urandom;
      patlen = $urandom_range(0, 8);
      for (int i = 0; i < patlen; i++) pat[i] = ($urandom_range(0, 2) != 0);
      build_model(nbeats, has_last);
      run_boot(nbeats, has_last, RunCycles);
      checks++;
      if (im_addr_q.size() != exp_addr_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_im_count: got %0d want %0d", it, im_addr_q.size(), exp_addr_q.size());
      end else begin
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          checks++;
          if (im_addr_q[i] != exp_addr_q[i] || im_data_q[i] !== exp_data_q[i]
              || im_edge_q[i] != exp_edge_q[i]) begin
            errors++;
            $display("FAIL rnd%0d_im[%0d]: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                     it, i, im_addr_q[i], im_data_q[i], im_edge_q[i], exp_addr_q[i],
                     exp_data_q[i], exp_edge_q[i]);
          end
        end
      end
      checks++;
      if (done_edge != exp_done || err_edge != exp_err || cpurst_edge != exp_done) begin
        errors++;
        $display("FAIL rnd%0d_status: got done %0d err %0d cpurst %0d want %0d %0d %0d",
                 it, done_edge, err_edge, cpurst_edge, exp_done, exp_err, exp_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_overflow();
    test_exact_fit();
    test_fill();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
